// File: rtl/reg8_reader.sv
// ---------------------------------------------------------------------------
// reg8_reader
//
// Read-side sequencer for an NREG x DW register file. A start pulse in IDLE
// walks the read select through entries 0..NREG-1. Each entry is captured
// one cycle after its select is applied, then offered downstream on a
// valid/ready stream while a running sum of the captured bytes is kept.
//
// Ports:
//   clk         in   system clock, rising edge
//   clr_n       in   synchronous active-low reset
//   start       in   begin a scan (only honoured in IDLE)
//   rsel        out  registered read select to the register file
//   q_in        in   register file read data (combinational from rsel)
//   dout        out  captured byte
//   dout_idx    out  entry index of dout
//   dout_valid  out  dout/dout_idx valid
//   dout_ready  in   consumer ready
//   busy        out  scan in progress (SAMPLE, SEND or DONE)
//   done        out  one-cycle pulse after the final handshake
//   sum         out  sum of all bytes captured in the current/last scan
//   dbg_state   out  current FSM state encoding (IDLE=0 SAMPLE=1 SEND=2 DONE=3)
//
// Stream handshake: a byte transfers on a rising edge where dout_valid and
// dout_ready are both high. Once raised, dout_valid, dout and dout_idx stay
// stable until that transfer. dout_valid is a register and never depends
// combinationally on dout_ready; dout_ready may be high before dout_valid.
// ---------------------------------------------------------------------------
module reg8_reader #(
   parameter int NREG = 8,
   parameter int DW   = 8,
   parameter int AW   = 3,
   parameter int SW   = 11
) (
   input  logic          clk,
   input  logic          clr_n,
   input  logic          start,
   output logic [AW-1:0] rsel,
   input  logic [DW-1:0] q_in,
   output logic [DW-1:0] dout,
   output logic [AW-1:0] dout_idx,
   output logic          dout_valid,
   input  logic          dout_ready,
   output logic          busy,
   output logic          done,
   output logic [SW-1:0] sum,
   output logic [1:0]    dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SAMPLE = 2'd1,
      ST_SEND   = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t        r_state;
   state_t        w_next;

   // The read select doubles as the scan index: during a scan it always
   // equals the entry being sampled/sent, and it must stay at NREG-1 after
   // the scan, which is exactly where the index finishes.
   logic [AW-1:0] r_rsel;
   logic [DW-1:0] r_dout;
   logic [AW-1:0] r_dout_idx;
   logic          r_dout_valid;
   logic [SW-1:0] r_sum;

   logic          w_hs;
   logic          w_last;

   assign w_hs   = (r_state == ST_SEND) && r_dout_valid && dout_ready;
   assign w_last = (r_rsel == AW'(NREG - 1));

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_next = ST_SAMPLE;
            end
         end
         ST_SAMPLE: begin
            w_next = ST_SEND;
         end
         ST_SEND: begin
            if (w_hs) begin
               w_next = w_last ? ST_DONE : ST_SAMPLE;
            end
         end
         ST_DONE: begin
            w_next = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         r_rsel       <= '0;
         r_dout       <= '0;
         r_dout_idx   <= '0;
         r_dout_valid <= 1'b0;
         r_sum        <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_rsel <= '0;
                  r_sum  <= '0;
               end
            end
            ST_SAMPLE: begin
               // rsel has been stable for a full cycle, so q_in is settled.
               r_dout       <= q_in;
               r_dout_idx   <= r_rsel;
               r_sum        <= r_sum + {{(SW - DW){1'b0}}, q_in};
               r_dout_valid <= 1'b1;
            end
            ST_SEND: begin
               if (w_hs) begin
                  r_dout_valid <= 1'b0;
                  // No increment on the last entry: the index never wraps.
                  if (!w_last) begin
                     r_rsel <= r_rsel + AW'(1);
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // ---------------- outputs ----------------
   assign rsel       = r_rsel;
   assign dout       = r_dout;
   assign dout_idx   = r_dout_idx;
   assign dout_valid = r_dout_valid;
   assign sum        = r_sum;
   assign busy       = (r_state != ST_IDLE);
   assign done       = (r_state == ST_DONE);
   assign dbg_state  = r_state;

endmodule

// File: tb/tb_reg8_reader.sv
// ---------------------------------------------------------------------------
// tb_reg8_reader
//
// Directed bench for reg8_reader. The register file is a small array in the
// bench whose read port is combinational from rsel. Inputs change 1 time unit
// after a rising edge and outputs are checked at that same point; a negedge
// monitor records every transferred byte and every done pulse.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_reg8_reader;

   localparam int NREG = 8;
   localparam int DW   = 8;
   localparam int AW   = 3;
   localparam int SW   = 11;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          clr_n;
   logic          start;
   logic [AW-1:0] rsel;
   logic [DW-1:0] q_in;
   logic [DW-1:0] dout;
   logic [AW-1:0] dout_idx;
   logic          dout_valid;
   logic          dout_ready;
   logic          busy;
   logic          done;
   logic [SW-1:0] sum;
   logic [1:0]    dbg_state;

   logic [DW-1:0] rf [NREG];
   assign q_in = rf[rsel];

   reg8_reader #(.NREG(NREG), .DW(DW), .AW(AW), .SW(SW)) dut (
      .clk        (clk),
      .clr_n      (clr_n),
      .start      (start),
      .rsel       (rsel),
      .q_in       (q_in),
      .dout       (dout),
      .dout_idx   (dout_idx),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .busy       (busy),
      .done       (done),
      .sum        (sum),
      .dbg_state  (dbg_state)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_pass   = 0;
   int done_cnt = 0;
   logic [AW+DW-1:0] obs_q [$];
   logic [AW+DW-1:0] exp_q [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end else begin
         n_pass++;
      end
   endtask

   // Records bytes that will transfer on the coming rising edge.
   always @(negedge clk) begin
      if (clr_n === 1'b1 && dout_valid === 1'b1 && dout_ready === 1'b1) begin
         obs_q.push_back({dout_idx, dout});
      end
      if (done === 1'b1) begin
         done_cnt++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_seq();
      for (int i = 0; i < NREG; i++) rf[i] = DW'(i + 1);
   endtask

   task automatic build_exp_from_rf();
      exp_q.delete();
      for (int i = 0; i < NREG; i++) exp_q.push_back({AW'(i), rf[i]});
   endtask

   task automatic start_scan();
      obs_q.delete();
      done_cnt = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Counts edges until done is seen; k = 0 means the budget expired.
   task automatic wait_done(output int k);
      k = 0;
      for (int i = 1; i <= 60; i++) begin
         tick();
         if (done === 1'b1) begin
            k = i;
            break;
         end
      end
      check("done_seen", (k != 0), 1);
   endtask

   task automatic wait_idx(input logic [AW-1:0] idx);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (dout_valid === 1'b1 && dout_idx === idx) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      check("idx_seen", found, 1);
   endtask

   task automatic compare_scan(input string tag);
      check({tag, "_count"}, obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         check($sformatf("%s_byte%0d", tag, i), obs_q[i], exp_q[i]);
      end
   endtask

   // ---------------- tests ----------------
   initial begin
      int k;
      clr_n      = 1'b0;
      start      = 1'b1;
      dout_ready = 1'b1;
      for (int i = 0; i < NREG; i++) rf[i] = '0;

      // Test 1: reset overrides start.
      for (int c = 0; c < 2; c++) begin
         tick();
         check("rst_state", dbg_state, 0);
         check("rst_outs", {rsel, dout, dout_idx, dout_valid, busy, done, sum}, 0);
      end
      start = 1'b0;
      clr_n = 1'b1;
      tick();
      check("idle_busy", busy, 0);

      // Test 2: sequential contents, ready tied high.
      load_seq();
      build_exp_from_rf();
      start_scan();                       // at E0 + 1
      check("t2_busy", busy, 1);
      tick();                             // E1: first byte offered
      check("t2_valid_e1", {dout_valid, dout_idx, dout}, {1'b1, 3'd0, 8'h01});
      wait_done(k);
      check("t2_done_lat", k, 15);        // done high after E16
      tick();
      check("t2_idle", {busy, done, dbg_state}, 0);
      check("t2_rsel", rsel, 7);
      check("t2_sum", sum, 11'h024);
      check("t2_done_cnt", done_cnt, 1);
      compare_scan("t2");

      // Test 3: back-pressure on entry 2.
      start_scan();
      wait_idx(3'd2);
      dout_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         check("t3_hold", {dout_valid, dout_idx, dout, rsel}, {1'b1, 3'd2, 8'h03, 3'd2});
      end
      dout_ready = 1'b1;
      wait_done(k);
      tick();
      check("t3_sum", sum, 11'h024);
      compare_scan("t3");

      // Test 4: all 0xFF, second start mid-scan ignored.
      for (int i = 0; i < NREG; i++) rf[i] = 8'hFF;
      build_exp_from_rf();
      start_scan();
      repeat (5) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(k);
      tick();
      tick();
      check("t4_sum", sum, 11'd2040);
      check("t4_done_cnt", done_cnt, 1);
      check("t4_idle", busy, 0);
      compare_scan("t4");

      // Test 5: reset mid-scan, then a clean restart.
      load_seq();
      build_exp_from_rf();
      start_scan();
      wait_idx(3'd4);
      clr_n = 1'b0;
      tick();
      check("t5_abort", {dout_valid, busy, done, sum, rsel}, 0);
      clr_n = 1'b1;
      repeat (3) tick();
      check("t5_no_done", done_cnt, 0);
      start_scan();
      wait_done(k);
      tick();
      check("t5_sum", sum, 11'h024);
      compare_scan("t5");

      // Test 6: write entry 6 while entry 3 is handed off.
      load_seq();
      start_scan();
      wait_idx(3'd3);
      rf[6] = 8'hAA;
      build_exp_from_rf();
      wait_done(k);
      tick();
      check("t6_sum", sum, 11'h0C7);      // 36 - 7 + 170
      compare_scan("t6");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
